lcd_refresh_sequencer: RTL and testbench
========================================

Name: lcd_refresh_sequencer

Overview:
- Continuously copies the 32-character display image (2 lines x 16 chars) from the character BRAM to the character LCD.
- Issues the DDRAM set-address command at the start of each line, then streams character bytes.
- Sits between the character BRAM (1-cycle synchronous read, 11-bit address, 8-bit data) and the byte-level LCD transmitter, which handles nibble splitting, enable pulsing and execution delays.
- Starts only after the LCD power-on init sequence reports done.

Parameters:
- CHARS_PER_LINE, 16, characters written per LCD line.
- BASE_ADDR, 11'd0, BRAM address of line-1 character 0; line 2 starts at BASE_ADDR+CHARS_PER_LINE.
- REFRESH_CYCLES, 1_000_000, idle clk cycles between the end of one frame and the start of the next (20 ms at 50 MHz).
- LINE1_CMD, 8'h80, set-DDRAM-address command for line 1.
- LINE2_CMD, 8'hC0, set-DDRAM-address command for line 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- init_done  in  1  level; LCD init sequence complete.
- refresh_now  in  1  one-cycle pulse; cut short the refresh wait.
- bram_address  out  11  character BRAM read address.
- bram_do  in  8  character BRAM data; valid one cycle after the address is sampled.
- tx_valid  out  1  byte available to the transmitter.
- tx_rs  out  1  0 = command, 1 = character data.
- tx_data  out  8  byte to send.
- tx_ready  in  1  transmitter can accept; a transfer occurs when tx_valid & tx_ready.
- tx_done  in  1  one-cycle pulse; accepted byte fully executed by the LCD.
- frame_done  out  1  one-cycle pulse after the last character of a frame completes.
- busy  out  1  high in every state except IDLE and WAIT_REFRESH.

Behaviour:
- Reset values: state IDLE, bram_address = BASE_ADDR, tx_valid = 0, tx_rs = 0, tx_data = 0, frame_done = 0, busy = 0, line = 0, char_idx = 0, refresh counter = 0.
- Reset mid-operation has the same effect on the next edge. Any pending transfer is abandoned; tx_valid falls immediately.
- All outputs are registered.
- States and transitions:
  - IDLE: when init_done = 1, go to CMD and load tx_data = LINE1_CMD, line = 0.
  - CMD: tx_valid = 1, tx_rs = 0, tx_data = LINE1_CMD or LINE2_CMD by line. On accept (valid & ready): tx_valid = 0, go to CMD_WAIT.
  - CMD_WAIT: on tx_done, go to FETCH with char_idx = 0.
  - FETCH: drive bram_address = BASE_ADDR + line*CHARS_PER_LINE + char_idx. Next state LATCH.
  - LATCH: BRAM output is now valid. Register tx_data <= bram_do, tx_rs <= 1, tx_valid <= 1. Go to SEND.
  - SEND: hold tx_valid, tx_rs and tx_data stable until accept. Then tx_valid = 0, go to DATA_WAIT.
  - DATA_WAIT: on tx_done:
    - if char_idx < CHARS_PER_LINE-1: char_idx++, go to FETCH;
    - else if line = 0: line = 1, go to CMD;
    - else: pulse frame_done for 1 cycle, clear the counter, go to WAIT_REFRESH.
  - WAIT_REFRESH: counter increments each cycle. Go to CMD with line = 0 when counter = REFRESH_CYCLES-1, or when refresh_now = 1, whichever is first.
- refresh_now is ignored outside WAIT_REFRESH.
- Latency:
  - FETCH to tx_valid high = 2 cycles.
  - tx_valid falls the cycle after accept.
  - tx_done is ignored outside CMD_WAIT and DATA_WAIT.
- init_done falling after start does not stop the frame. It is sampled only in IDLE.
- Address arithmetic is 11-bit, wraps modulo 2048, and is never out of range for the defaults.
- One frame = 2 commands + 2*CHARS_PER_LINE data bytes, in strict order, with no reordering or skipping.

Decomposition:
- Shared lcd_pkg holds:
  - the state encoding constants;
  - LCD command constants (LINE1_CMD, LINE2_CMD, clear/entry-mode codes used by the init block);
  - RS encodings (RS_CMD = 0, RS_DATA = 1).
- One natural sub-module: lcd_refresh_timer (REFRESH_CYCLES counter with start/force/expire).
- Everything else is a single FSM in lcd_refresh_sequencer.

Test Plan:
- Full frame. Stimulus: REFRESH_CYCLES = 100, BRAM holds 0x00..0x1F at 0..31, init_done = 1, tx_ready = 1, tx_done 3 cycles after each accept. Required: bytes (rs,data) = (0,80), (1,00)..(1,0F), (0,C0), (1,10)..(1,1F); frame_done pulses once; the next (0,80) is accepted 100 cycles after frame_done.
- Backpressure. Stimulus: tx_ready held low for 10 cycles during the 5th character. Required: tx_valid, tx_rs = 1, tx_data = 0x04 stay stable all 10 cycles; exactly one transfer is counted.
- Init gating. Stimulus: init_done = 0 for 500 cycles. Required: tx_valid = 0, busy = 0 throughout; first (0,80) appears after init_done rises.
- refresh_now. Stimulus: pulse refresh_now 5 cycles into WAIT_REFRESH. Required: next cycle state is CMD and (0,80) is presented, without waiting the full count.
- Reset mid-frame. Stimulus: reset asserted 1 cycle while sending char 0x12. Required: next cycle tx_valid = 0, bram_address = 0, busy = 0; after release, the frame restarts with (0,80).
- Stray tx_done. Stimulus: tx_done pulsed during SEND and during WAIT_REFRESH. Required: no state advance and no skipped character.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD state encoding, command codes and RS encodings
//
// Purpose: constants shared by the LCD init block and the refresh sequencer.
// Ports:   none (package).

package lcd_pkg;

  // Refresh sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_CMD_WAIT,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_DATA_WAIT,
    ST_WAIT_REFRESH
  } state_t;

  // HD44780-style command bytes.
  localparam logic [7:0] LCD_LINE1_CMD        = 8'h80;
  localparam logic [7:0] LCD_LINE2_CMD        = 8'hC0;
  localparam logic [7:0] LCD_CLEAR_CMD        = 8'h01;
  localparam logic [7:0] LCD_ENTRY_MODE_CMD   = 8'h06;
  localparam logic [7:0] LCD_DISPLAY_ON_CMD   = 8'h0C;
  localparam logic [7:0] LCD_FUNCTION_SET_CMD = 8'h28;

  // Register-select encodings.
  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  // BRAM address of a character: base + line offset + index, modulo 2048.
  function automatic logic [10:0] char_address(input logic [10:0] base,
                                               input logic        line,
                                               input logic [10:0] stride,
                                               input logic [10:0] idx);
    return base + (line ? stride : 11'd0) + idx;
  endfunction

endpackage

// File: rtl/lcd_refresh_timer.sv
// rtl/lcd_refresh_timer.sv - idle-interval counter between display frames
//
// Purpose: counts cycles while run is high; expired flags the last cycle of
//          the interval, or any cycle in which cut_short is raised.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   start        in   clear the count (start of a new interval)
//   run          in   count this cycle
//   cut_short    in   end the interval early (only honoured while run)
//   expired      out  interval over this cycle (combinational)

module lcd_refresh_timer #(
  parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  input  logic cut_short,
  output logic expired
);

  localparam int CW = $clog2(REFRESH_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (run) begin
      count <= count + CW'(1);
    end
  end

  assign expired = run & (cut_short | (count == CW'(REFRESH_CYCLES - 1)));

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// rtl/lcd_refresh_sequencer.sv - copies the 2x16 character image from BRAM to the LCD
//
// Purpose: after LCD init completes, repeatedly sends set-address command +
//          16 characters for each of the two lines, then idles for a refresh
//          interval (or until refresh_now) before the next frame.
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   init_done     in   LCD init sequence complete (sampled in IDLE only)
//   refresh_now   in   pulse; ends the refresh wait early
//   bram_address  out  character BRAM read address
//   bram_do       in   character BRAM data, one cycle after address
//   tx_valid      out  byte available to transmitter
//   tx_rs         out  0 = command, 1 = character
//   tx_data       out  byte to send
//   tx_ready      in   transmitter accepts when tx_valid & tx_ready
//   tx_done       in   pulse; accepted byte executed by the LCD
//   frame_done    out  pulse after the last character of a frame
//   busy          out  high except in IDLE and WAIT_REFRESH

module lcd_refresh_sequencer #(
  parameter int          CHARS_PER_LINE = 16,
  parameter logic [10:0] BASE_ADDR      = 11'd0,
  parameter int unsigned REFRESH_CYCLES = 1_000_000,
  parameter logic [7:0]  LINE1_CMD      = lcd_pkg::LCD_LINE1_CMD,
  parameter logic [7:0]  LINE2_CMD      = lcd_pkg::LCD_LINE2_CMD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_done,
  input  logic        refresh_now,
  output logic [10:0] bram_address,
  input  logic [7:0]  bram_do,
  output logic        tx_valid,
  output logic        tx_rs,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        tx_done,
  output logic        frame_done,
  output logic        busy
);

  import lcd_pkg::*;

  localparam int             IW          = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1;
  localparam logic [IW-1:0]  LAST_IDX    = IW'(CHARS_PER_LINE - 1);
  localparam logic [10:0]    LINE_STRIDE = 11'(CHARS_PER_LINE);

  state_t        state, state_n;
  logic          line, line_n;
  logic [IW-1:0] char_idx, char_idx_n;
  logic [10:0]   addr_n;
  logic          tx_valid_n, tx_rs_n;
  logic [7:0]    tx_data_n;
  logic          frame_done_n, busy_n;
  logic          accept;
  logic          timer_start, timer_run, timer_expired;

  assign accept    = tx_valid & tx_ready;
  assign timer_run = (state == ST_WAIT_REFRESH);

  lcd_refresh_timer #(
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .start     (timer_start),
    .run       (timer_run),
    .cut_short (refresh_now),
    .expired   (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      line         <= 1'b0;
      char_idx     <= '0;
      bram_address <= BASE_ADDR;
      tx_valid     <= 1'b0;
      tx_rs        <= RS_CMD;
      tx_data      <= 8'h00;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      line         <= line_n;
      char_idx     <= char_idx_n;
      bram_address <= addr_n;
      tx_valid     <= tx_valid_n;
      tx_rs        <= tx_rs_n;
      tx_data      <= tx_data_n;
      frame_done   <= frame_done_n;
      busy         <= busy_n;
    end
  end

  // Outputs are registered, so every transition that presents a byte also
  // loads valid/rs/data here: the byte is on the bus in the first cycle of
  // the destination state.
  always_comb begin
    state_n      = state;
    line_n       = line;
    char_idx_n   = char_idx;
    addr_n       = bram_address;
    tx_valid_n   = tx_valid;
    tx_rs_n      = tx_rs;
    tx_data_n    = tx_data;
    frame_done_n = 1'b0;
    timer_start  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (init_done) begin
          state_n    = ST_CMD;
          line_n     = 1'b0;
          tx_valid_n = 1'b1;
          tx_rs_n    = RS_CMD;
          tx_data_n  = LINE1_CMD;
        end
      end
      ST_CMD: begin
        if (accept) begin
          tx_valid_n = 1'b0;
          state_n    = ST_CMD_WAIT;
        end
      end
      ST_CMD_WAIT: begin
        if (tx_done) begin
          state_n    = ST_FETCH;
          char_idx_n = '0;
          addr_n     = char_address(BASE_ADDR, line, LINE_STRIDE, 11'd0);
        end
      end
      // Address is already on the BRAM port; data arrives next cycle.
      ST_FETCH: begin
        state_n = ST_LATCH;
      end
      ST_LATCH: begin
        tx_data_n  = bram_do;
        tx_rs_n    = RS_DATA;
        tx_valid_n = 1'b1;
        state_n    = ST_SEND;
      end
      ST_SEND: begin
        if (accept) begin
          tx_valid_n = 1'b0;
          state_n    = ST_DATA_WAIT;
        end
      end
      ST_DATA_WAIT: begin
        if (tx_done) begin
          if (char_idx != LAST_IDX) begin
            char_idx_n = char_idx + IW'(1);
            addr_n     = char_address(BASE_ADDR, line, LINE_STRIDE, 11'(char_idx) + 11'd1);
            state_n    = ST_FETCH;
          end else if (!line) begin
            line_n     = 1'b1;
            tx_valid_n = 1'b1;
            tx_rs_n    = RS_CMD;
            tx_data_n  = LINE2_CMD;
            state_n    = ST_CMD;
          end else begin
            frame_done_n = 1'b1;
            timer_start  = 1'b1;
            state_n      = ST_WAIT_REFRESH;
          end
        end
      end
      ST_WAIT_REFRESH: begin
        if (timer_expired) begin
          line_n     = 1'b0;
          tx_valid_n = 1'b1;
          tx_rs_n    = RS_CMD;
          tx_data_n  = LINE1_CMD;
          state_n    = ST_CMD;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE) && (state_n != ST_WAIT_REFRESH);
  end

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// tb/tb_lcd_refresh_sequencer.sv - directed self-checking bench for lcd_refresh_sequencer

module tb_lcd_refresh_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_done;
  logic        refresh_now;
  logic [10:0] bram_address;
  logic [7:0]  bram_do;
  logic        tx_valid;
  logic        tx_rs;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_done;
  logic        frame_done;
  logic        busy;

  logic        stray_done;
  logic [2:0]  done_pipe;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          fd_count = 0;
  int          fd_cycle = 0;
  logic [8:0]  log_q[$];
  int          acc_cyc[$];
  logic [7:0]  mem[0:2047];

  always #5 clk = ~clk;

  lcd_refresh_sequencer #(
    .CHARS_PER_LINE (16),
    .BASE_ADDR      (11'd0),
    .REFRESH_CYCLES (100),
    .LINE1_CMD      (8'h80),
    .LINE2_CMD      (8'hC0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .init_done    (init_done),
    .refresh_now  (refresh_now),
    .bram_address (bram_address),
    .bram_do      (bram_do),
    .tx_valid     (tx_valid),
    .tx_rs        (tx_rs),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  // Character BRAM: 1-cycle synchronous read.
  always @(posedge clk) bram_do <= mem[bram_address];

  // Transmitter model: log accepted bytes, pulse tx_done 3 cycles later.
  assign tx_done = done_pipe[2] | stray_done;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (frame_done === 1'b1) begin
      fd_count = fd_count + 1;
      fd_cycle = cyc;
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      log_q.push_back({tx_rs, tx_data});
      acc_cyc.push_back(cyc);
    end
    done_pipe <= {done_pipe[1:0], (tx_valid === 1'b1 && tx_ready === 1'b1)};
  end

  function automatic logic [8:0] exp_byte(input int i);
    if (i == 0)       return 9'h080;
    else if (i <= 16) return {1'b1, 8'(i - 1)};
    else if (i == 17) return 9'h0C0;
    else              return {1'b1, 8'(i - 2)};
  endfunction

  task automatic wait_log(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (log_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %0b want 0", tx_valid); end
    n_checks++; if (tx_rs !== 1'b0) begin n_fail++; $display("FAIL reset_tx_rs got %0b want 0", tx_rs); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    n_checks++; if (bram_address !== 11'd0) begin n_fail++; $display("FAIL reset_bram_address got %0d want 0", bram_address); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %0b want 0", frame_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_init_gating;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL gating_tx_valid cycle %0d got %0b want 0", i, tx_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gating_busy cycle %0d got %0b want 0", i, busy); end
    end
    n_checks++; if (log_q.size() != 0) begin n_fail++; $display("FAIL gating_no_bytes got %0d want 0", log_q.size()); end
    init_done = 1'b1;
    @(negedge clk);
    n_checks++; if ({tx_valid, tx_rs, tx_data} !== {1'b1, 1'b0, 8'h80}) begin
      n_fail++; $display("FAIL gating_first_cmd got v=%0b rs=%0b d=%h want v=1 rs=0 d=80", tx_valid, tx_rs, tx_data);
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gating_busy_after got %0b want 1", busy); end
    init_done = 1'b0;  // falling after start must not stop the frame
  endtask

  task automatic test_full_frame;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (fd_count >= 1) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frame1_timeout got fd_count=%0d want 1", fd_count); end
    n_checks++; if (log_q.size() != 34) begin n_fail++; $display("FAIL frame1_length got %0d want 34", log_q.size()); end
    for (int i = 0; i < 34 && i < log_q.size(); i++) begin
      n_checks++; if (log_q[i] !== exp_byte(i)) begin
        n_fail++; $display("FAIL frame1_byte[%0d] got %h want %h", i, log_q[i], exp_byte(i));
      end
    end
    init_done = 1'b1;
    wait_log(35, 300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frame2_start_timeout got %0d bytes want 35", log_q.size()); end
    if (ok) begin
      n_checks++; if (log_q[34] !== 9'h080) begin n_fail++; $display("FAIL frame2_first_byte got %h want 080", log_q[34]); end
      n_checks++; if (acc_cyc[34] - fd_cycle != 100) begin
        n_fail++; $display("FAIL refresh_interval got %0d want 100", acc_cyc[34] - fd_cycle);
      end
    end
    n_checks++; if (fd_count != 1) begin n_fail++; $display("FAIL frame1_done_count got %0d want 1", fd_count); end
  endtask

  task automatic test_backpressure;
    bit ok;
    bit seen;
    wait_log(39, 400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_reach_char4 got %0d bytes want 39", log_q.size()); end
    tx_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_valid_timeout got 0 want 1"); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if ({tx_valid, tx_rs, tx_data} !== {1'b1, 1'b1, 8'h04}) begin
        n_fail++; $display("FAIL bp_hold cycle %0d got v=%0b rs=%0b d=%h want v=1 rs=1 d=04", i, tx_valid, tx_rs, tx_data);
      end
      n_checks++; if (log_q.size() != 39) begin n_fail++; $display("FAIL bp_no_transfer cycle %0d got %0d want 39", i, log_q.size()); end
      @(negedge clk);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (log_q.size() != 40) begin n_fail++; $display("FAIL bp_one_transfer got %0d want 40", log_q.size()); end
    n_checks++; if (log_q.size() >= 40 && log_q[39] !== 9'h104) begin n_fail++; $display("FAIL bp_byte got %h want 104", log_q[39]); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_fall got %0b want 0", tx_valid); end
    wait_log(68, 400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frame2_timeout got %0d want 68", log_q.size()); end
    for (int i = 0; i < 34 && 34 + i < log_q.size(); i++) begin
      n_checks++; if (log_q[34 + i] !== exp_byte(i)) begin
        n_fail++; $display("FAIL frame2_byte[%0d] got %h want %h", i, log_q[34 + i], exp_byte(i));
      end
    end
  endtask

  task automatic test_refresh_now;
    bit seen;
    int base;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rn_frame_done_timeout got 0 want 1"); end
    base = log_q.size();
    @(negedge clk);
    @(negedge clk);
    stray_done = 1'b1;  // stray tx_done inside WAIT_REFRESH
    @(negedge clk);
    stray_done = 1'b0;
    n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stray_wait_refresh got v=%0b busy=%0b want v=0 busy=0", tx_valid, busy);
    end
    @(negedge clk);
    @(negedge clk);
    refresh_now = 1'b1;
    @(negedge clk);
    refresh_now = 1'b0;
    n_checks++; if ({tx_valid, tx_rs, tx_data} !== {1'b1, 1'b0, 8'h80}) begin
      n_fail++; $display("FAIL rn_cmd got v=%0b rs=%0b d=%h want v=1 rs=0 d=80", tx_valid, tx_rs, tx_data);
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rn_busy got %0b want 1", busy); end
    n_checks++; if (log_q.size() != base) begin n_fail++; $display("FAIL rn_no_early_bytes got %0d want %0d", log_q.size(), base); end
  endtask

  task automatic test_stray_done;
    bit ok;
    bit seen;
    wait_log(71, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stray_reach_char2 got %0d want 71", log_q.size()); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL stray_valid_timeout got 0 want 1"); end
    tx_ready   = 1'b0;
    stray_done = 1'b1;  // stray tx_done inside SEND
    @(negedge clk);
    stray_done = 1'b0;
    n_checks++; if ({tx_valid, tx_rs, tx_data} !== {1'b1, 1'b1, 8'h02}) begin
      n_fail++; $display("FAIL stray_send_hold got v=%0b rs=%0b d=%h want v=1 rs=1 d=02", tx_valid, tx_rs, tx_data);
    end
    repeat (2) @(negedge clk);
    tx_ready = 1'b1;
    wait_log(102, 400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frame3_timeout got %0d want 102", log_q.size()); end
    for (int i = 0; i < 34 && 68 + i < log_q.size(); i++) begin
      n_checks++; if (log_q[68 + i] !== exp_byte(i)) begin
        n_fail++; $display("FAIL frame3_byte[%0d] got %h want %h", i, log_q[68 + i], exp_byte(i));
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    bit seen;
    int base;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_valid === 1'b1 && tx_rs === 1'b1 && tx_data === 8'h12) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_char12_timeout got 0 want 1"); end
    reset    = 1'b1;
    tx_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got %0b want 0", tx_valid); end
    n_checks++; if (bram_address !== 11'd0) begin n_fail++; $display("FAIL rst_bram_address got %0d want 0", bram_address); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", busy); end
    reset    = 1'b0;
    tx_ready = 1'b1;
    base = log_q.size();
    wait_log(base + 34, 400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_restart_timeout got %0d want %0d", log_q.size(), base + 34); end
    for (int i = 0; i < 34 && base + i < log_q.size(); i++) begin
      n_checks++; if (log_q[base + i] !== exp_byte(i)) begin
        n_fail++; $display("FAIL rst_frame_byte[%0d] got %h want %h", i, log_q[base + i], exp_byte(i));
      end
    end
    repeat (6) @(negedge clk);
    n_checks++; if (fd_count != 4) begin n_fail++; $display("FAIL total_frame_done got %0d want 4", fd_count); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = (i < 32) ? 8'(i) : 8'hEE;
    reset       = 1'b1;
    init_done   = 1'b0;
    refresh_now = 1'b0;
    tx_ready    = 1'b1;
    stray_done  = 1'b0;
    done_pipe   = 3'b000;

    test_reset;
    test_init_gating;
    test_full_frame;
    test_backpressure;
    test_refresh_now;
    test_stray_done;
    test_reset_mid_frame;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
